// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) with annul support.
// Optional build macro DIV_EARLY_OUT_EN: finish immediately when |dividend| < |divisor|.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] mag1, mag2;
  logic             accept, iterate;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    logic signed [WIDTH-1:0] s;
    s = $signed(v);
    return (is_signed && s < 0) ? $unsigned(-s) : v;
  endfunction

  function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // One restoring step: shift {rem,quo} left, keep the difference when it does not go negative.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] diff;
    sh   = {rem, quo[WIDTH-1]};
    diff = sh[WIDTH-1:0] - dvs;
    if (sh >= {1'b0, dvs}) return {diff, quo[WIDTH-2:0], 1'b1};
    else                   return {sh[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
  endfunction

  assign mag1    = magnitude(opdata1_i, signed_div_i);
  assign mag2    = magnitude(opdata2_i, signed_div_i);
  assign accept  = (state == S_IDLE) && start_i && !annul_i;
  assign iterate = (state == S_ON) && !annul_i && (cnt != CNT_LAST);

  // Datapath registers carry no reset; they are always reloaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_r <= '0;
      quo_r <= mag1;
      dvs_r <= mag2;
      neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
      neg_r <= signed_div_i & opdata1_i[WIDTH-1];
    end else if (iterate) begin
      {rem_r, quo_r} <= div_step(rem_r, quo_r, dvs_r);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (opdata2_i == '0) begin
              state  <= S_BYZERO;
              busy_o <= 1'b1;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (mag1 < mag2) begin
              state    <= S_END;
              result_o <= {opdata1_i, {WIDTH{1'b0}}};
              ready_o  <= 1'b1;
            end
`endif
            else begin
              state  <= S_ON;
              busy_o <= 1'b1;
            end
          end
        end
        S_BYZERO: begin
          state    <= S_END;
          busy_o   <= 1'b0;
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        S_ON: begin
          if (annul_i) begin
            state    <= S_IDLE;
            busy_o   <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CNT_ONE;
          end else begin
            state    <= S_END;
            busy_o   <= 1'b0;
            result_o <= {negate_if(rem_r, neg_r), negate_if(quo_r, neg_q)};
            ready_o  <= 1'b1;
          end
        end
        S_END: begin
          if (!start_i) begin
            state    <= S_IDLE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
